// File: rtl/matrix_pkg.sv
// Shared geometry, request record and arbiter state for the matrix register-file write path.
// Pure declarations; no latency or flow-control of its own.
package matrix_pkg;

  localparam int MRF_N_SRC  = 3;
  localparam int MRF_RLEN   = 128;
  localparam int MRF_N_REGS = 8;
  localparam int MRF_N_ROWS = 4;

  localparam int REG_AW = $clog2(MRF_N_REGS);
  localparam int ROW_AW = $clog2(MRF_N_ROWS);
  localparam int SRC_W  = $clog2(MRF_N_SRC);

  typedef struct packed {
    logic [REG_AW-1:0]   waddr;
    logic [ROW_AW-1:0]   wrowaddr;
    logic [MRF_RLEN-1:0] wdata;
  } rf_wreq_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

endpackage

// File: rtl/matrix_rr_pick.sv
// Round-robin picker: first requester at or above ptr_i, wrapping; zero latency.
// No flow control; purely combinational.
module matrix_rr_pick #(
  parameter int N = 3,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         vld_o
);

  // One spare bit so ptr+i cannot overflow before the modulo-N fold.
  logic [W:0] pos;

  always_comb begin
    pos   = '0;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr_i} + (W+1)'(i);
      if (pos >= (W+1)'(N)) pos = pos - (W+1)'(N);
      if (!vld_o && req_i[pos[W-1:0]]) begin
        vld_o              = 1'b1;
        gnt_o[pos[W-1:0]]  = 1'b1;
        idx_o              = pos[W-1:0];
      end
    end
  end

endmodule

// File: rtl/matrix_rf_wport_arbiter.sv
// Burst-locked round-robin arbiter onto the matrix RF write port; zero-cycle mux.
// rf_wready_i low stalls every source and freezes all state.
module matrix_rf_wport_arbiter
  import matrix_pkg::*;
#(
  parameter int N_SRC  = MRF_N_SRC,
  parameter int RLEN   = MRF_RLEN,
  parameter int N_REGS = MRF_N_REGS,
  parameter int N_ROWS = MRF_N_ROWS
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_SRC*REG_AW-1:0] src_waddr_i,
  input  logic [N_SRC*ROW_AW-1:0] src_wrowaddr_i,
  input  logic [N_SRC*RLEN-1:0]   src_wdata_i,
  input  logic [N_SRC-1:0]        src_we_i,
  input  logic [N_SRC-1:0]        src_wlast_i,
  output logic [N_SRC-1:0]        src_wready_o,
  output logic [REG_AW-1:0]       rf_waddr_o,
  output logic [ROW_AW-1:0]       rf_wrowaddr_o,
  output logic [RLEN-1:0]         rf_wdata_o,
  output logic                    rf_we_o,
  input  logic                    rf_wready_i,
  output logic                    owner_valid_o,
  output logic [SRC_W-1:0]        owner_o,
  output logic                    proto_err_o
);

  if (N_SRC < 2 || N_ROWS < 2) begin : g_bad_geom
    $error("matrix_rf_wport_arbiter: N_SRC and N_ROWS must both be at least 2");
  end
  // The request record layout comes from the package, so geometry must agree with it.
  if (N_SRC != MRF_N_SRC || RLEN != MRF_RLEN || N_REGS != MRF_N_REGS || N_ROWS != MRF_N_ROWS)
  begin : g_pkg_mismatch
    $error("matrix_rf_wport_arbiter: parameters disagree with matrix_pkg geometry");
  end

  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(N_ROWS - 1);

  arb_state_e        state_q, state_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d, owner_q, owner_d;
  logic [ROW_AW-1:0] beat_cnt_q, beat_cnt_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  logic [N_SRC-1:0]  pick_gnt, grant;
  logic [SRC_W-1:0]  pick_idx, gidx;
  logic              pick_vld, gvld, acc, last;
  rf_wreq_t          sel;

  matrix_rr_pick #(.N(N_SRC), .W(SRC_W)) u_rr_pick (
    .req_i (src_we_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  // While locked the owner keeps the port even when it idles its we.
  always_comb begin
    grant = pick_gnt;
    gidx  = pick_idx;
    gvld  = pick_vld;
    if (state_q == ARB_LOCKED) begin
      grant        = '0;
      grant[owner_q] = 1'b1;
      gidx         = owner_q;
      gvld         = 1'b1;
    end
    sel = '0;
    if (gvld) begin
      sel.waddr    = src_waddr_i[gidx*REG_AW +: REG_AW];
      sel.wrowaddr = src_wrowaddr_i[gidx*ROW_AW +: ROW_AW];
      sel.wdata    = src_wdata_i[gidx*RLEN +: RLEN];
    end
  end

  assign acc  = gvld & src_we_i[gidx] & rf_wready_i;
  assign last = src_wlast_i[gidx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      addr_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    addr_d     = addr_q;
    err_d      = err_q;
    if (acc) begin
      if (sel.wrowaddr != beat_cnt_q)                       err_d = 1'b1;
      if (last && beat_cnt_q != LAST_ROW)                   err_d = 1'b1;
      if (!last && beat_cnt_q == LAST_ROW)                  err_d = 1'b1;
      if (state_q == ARB_LOCKED && sel.waddr != addr_q)     err_d = 1'b1;
      if (last) begin
        state_d    = ARB_IDLE;
        beat_cnt_d = '0;
        rr_ptr_d   = (gidx == SRC_W'(N_SRC - 1)) ? '0 : gidx + 1'b1;
      end else begin
        state_d    = ARB_LOCKED;
        owner_d    = gidx;
        beat_cnt_d = (beat_cnt_q == LAST_ROW) ? '0 : beat_cnt_q + 1'b1;
        if (state_q == ARB_IDLE) addr_d = sel.waddr;
      end
    end
  end

  always_comb begin
    src_wready_o  = grant & {N_SRC{rf_wready_i}};
    rf_waddr_o    = sel.waddr;
    rf_wrowaddr_o = sel.wrowaddr;
    rf_wdata_o    = sel.wdata;
    rf_we_o       = gvld & src_we_i[gidx];
    owner_valid_o = (state_q == ARB_LOCKED);
    owner_o       = (state_q == ARB_LOCKED) ? owner_q : '0;
    proto_err_o   = err_q;
  end

  a_grant_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(grant));

endmodule

// File: tb/tb_matrix_rf_wport_arbiter.sv
// Directed vector bench for the matrix RF write-port arbiter (3 sources, 4-row bursts).
module tb_matrix_rf_wport_arbiter;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic [8:0]     src_waddr_i;
  logic [5:0]     src_wrowaddr_i;
  logic [383:0]   src_wdata_i;
  logic [2:0]     src_we_i, src_wlast_i, src_wready_o;
  logic [2:0]     rf_waddr_o;
  logic [1:0]     rf_wrowaddr_o, owner_o;
  logic [127:0]   rf_wdata_o;
  logic           rf_we_o, rf_wready_i, owner_valid_o, proto_err_o;

  always #5 clk_i = ~clk_i;

  matrix_rf_wport_arbiter dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .src_waddr_i    (src_waddr_i),
    .src_wrowaddr_i (src_wrowaddr_i),
    .src_wdata_i    (src_wdata_i),
    .src_we_i       (src_we_i),
    .src_wlast_i    (src_wlast_i),
    .src_wready_o   (src_wready_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wrowaddr_o  (rf_wrowaddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .rf_we_o        (rf_we_o),
    .rf_wready_i    (rf_wready_i),
    .owner_valid_o  (owner_valid_o),
    .owner_o        (owner_o),
    .proto_err_o    (proto_err_o)
  );

  typedef struct {
    bit         rst;
    logic [2:0] we, last;
    logic [5:0] rows;
    logic       rdy;
    logic [2:0] x_wr;
    logic       x_we;
    logic [1:0] x_row;
    logic       x_gv;
    logic [1:0] x_gs;
    logic       x_ov;
    logic [1:0] x_own;
    logic       x_err;
  } vec_t;

  vec_t         tbl[$];
  logic [2:0]   addr_of [3];
  logic [127:0] data_of [3];
  int           vectors = 0;
  int           miscompares = 0;

  function automatic vec_t mk(bit rst, logic [2:0] we, logic [2:0] last, int r2, int r1, int r0,
                              logic rdy, logic [2:0] wr, logic rfwe, int row, logic gv, int gs,
                              logic ov, int own, logic err);
    vec_t v;
    v.rst = rst;  v.we = we;  v.last = last;
    v.rows = {2'(r2), 2'(r1), 2'(r0)};
    v.rdy = rdy;  v.x_wr = wr;  v.x_we = rfwe;  v.x_row = 2'(row);
    v.x_gv = gv;  v.x_gs = 2'(gs);  v.x_ov = ov;  v.x_own = 2'(own);  v.x_err = err;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL vec %0d %s: got %0h, expected %0h", idx, name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    src_we_i       = v.we;
    src_wlast_i    = v.last;
    src_wrowaddr_i = v.rows;
    rf_wready_i    = v.rdy;
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [127:0] xd;
    logic [2:0]   xa;
    @(negedge clk_i);
    if (v.rst) begin
      src_we_i = '0;
      rst_ni   = 1'b0;
      #1;
      rst_ni   = 1'b1;
    end
    drive(v);
    #2;
    xd = v.x_gv ? data_of[v.x_gs] : '0;
    xa = v.x_gv ? addr_of[v.x_gs] : '0;
    chk("src_wready", idx, 128'(src_wready_o), 128'(v.x_wr));
    chk("rf_we",      idx, 128'(rf_we_o),      128'(v.x_we));
    chk("rf_wrowaddr",idx, 128'(rf_wrowaddr_o),128'(v.x_row));
    chk("rf_waddr",   idx, 128'(rf_waddr_o),   128'(xa));
    chk("rf_wdata",   idx, rf_wdata_o,         xd);
    chk("owner_valid",idx, 128'(owner_valid_o),128'(v.x_ov));
    chk("owner",      idx, 128'(owner_o),      128'(v.x_own));
    chk("proto_err",  idx, 128'(proto_err_o),  128'(v.x_err));
    vectors++;
  endtask

  initial begin
    addr_of = '{3'd3, 3'd5, 3'd6};
    data_of = '{{4{32'hA000_0000}}, {4{32'hB111_1111}}, {4{32'hC222_2222}}};
    src_waddr_i = {addr_of[2], addr_of[1], addr_of[0]};
    src_wdata_i = {data_of[2], data_of[1], data_of[0]};
    rst_ni = 1'b0;  src_we_i = '0;  src_wlast_i = '0;  src_wrowaddr_i = '0;  rf_wready_i = 1'b1;

    //            rst we      last    r2 r1 r0 rdy  wready  we row gv gs ov own err
    // single source 0 burst to reg 3
    tbl.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 0, 0, 0, 1, 3'b001, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 0, 0, 1, 1, 3'b001, 1, 1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 0, 0, 2, 1, 3'b001, 1, 2, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b001, 0, 0, 3, 1, 3'b001, 1, 3, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    // sources 0 and 2 together from reset: 0 first, 2 blocked
    tbl.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b101, 3'b000, 0, 0, 0, 1, 3'b001, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b101, 3'b000, 0, 0, 1, 1, 3'b001, 1, 1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3'b101, 3'b000, 0, 0, 2, 1, 3'b001, 1, 2, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3'b101, 3'b001, 0, 0, 3, 1, 3'b001, 1, 3, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3'b100, 3'b000, 0, 0, 0, 1, 3'b100, 1, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 3'b100, 3'b000, 1, 0, 0, 1, 3'b100, 1, 1, 1, 2, 1, 2, 0));
    tbl.push_back(mk(0, 3'b100, 3'b000, 2, 0, 0, 1, 3'b100, 1, 2, 1, 2, 1, 2, 0));
    tbl.push_back(mk(0, 3'b100, 3'b100, 3, 0, 0, 1, 3'b100, 1, 3, 1, 2, 1, 2, 0));
    // all three contending continuously: order 0,1,2,0
    for (int s = 0; s < 3; s++) begin
      for (int r = 0; r < 4; r++) begin
        tbl.push_back(mk(0, 3'b111, (r == 3) ? 3'(1 << s) : 3'b000,
                         (s == 2) ? r : 0, (s == 1) ? r : 0, (s == 0) ? r : 0, 1,
                         3'(1 << s), 1, r, 1, s, (r != 0), (r != 0) ? s : 0, 0));
      end
    end
    tbl.push_back(mk(0, 3'b111, 3'b000, 0, 0, 0, 1, 3'b001, 1, 0, 1, 0, 0, 0, 0));
    // back-pressure on beat 2 for three cycles
    tbl.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 0, 0, 0, 1, 3'b001, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 0, 0, 1, 1, 3'b001, 1, 1, 1, 0, 1, 0, 0));
    for (int c = 0; c < 3; c++)
      tbl.push_back(mk(0, 3'b001, 3'b000, 0, 0, 2, 0, 3'b000, 1, 2, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 0, 0, 2, 1, 3'b001, 1, 2, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b001, 0, 0, 3, 1, 3'b001, 1, 3, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    // owner stalls two cycles while source 1 waits
    tbl.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 0, 0, 0, 1, 3'b001, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b011, 3'b000, 0, 0, 1, 1, 3'b001, 1, 1, 1, 0, 1, 0, 0));
    for (int c = 0; c < 2; c++)
      tbl.push_back(mk(0, 3'b010, 3'b000, 0, 0, 2, 1, 3'b001, 0, 2, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3'b011, 3'b000, 0, 0, 2, 1, 3'b001, 1, 2, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3'b011, 3'b001, 0, 0, 3, 1, 3'b001, 1, 3, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, 0, 0, 0, 1, 3'b010, 1, 0, 1, 1, 0, 0, 0));
    // early wlast on row 1: sticky error, back to idle, reset clears
    tbl.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, 0, 0, 0, 1, 3'b010, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 3'b010, 0, 1, 0, 1, 3'b010, 1, 1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    // first beat carrying the wrong row index
    tbl.push_back(mk(0, 3'b100, 3'b000, 1, 0, 0, 1, 3'b100, 1, 1, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 1, 3'b100, 0, 0, 1, 2, 1, 2, 1));
    tbl.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[k]) apply(tbl[k], k);

    // reset mid-burst drops the lock and rewinds the round-robin pointer
    @(negedge clk_i);
    drive(mk(0, 3'b010, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk_i);
    #1;
    chk("mid_lock_ov", -1, 128'(owner_valid_o), 128'(1'b1));
    chk("mid_lock_own", -1, 128'(owner_o), 128'(2'd1));
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_ov", -1, 128'(owner_valid_o), 128'(1'b0));
    rst_ni = 1'b1;
    src_we_i = 3'b110;
    #1;
    chk("mid_rst_rr", -1, 128'(src_wready_o), 128'(3'b010));
    vectors++;

    src_we_i = '0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
